tff_bank_multimode: RTL and testbench
=====================================

Name: tff_bank_multimode

Overview:
Parametrised bank of WIDTH independent flip-flop channels. This is the next generation of the team's single T flip-flop. Each cycle, a shared 2-bit mode selects T, D, JK or SR behaviour for all channels. Inputs pass through an optional synchroniser chain, and T/JK/SR commands can be level- or rising-edge-qualified. Includes parallel load, a change strobe and a saturating change-event counter, and sits directly behind the tile's dedicated input pins.

Parameters:
WIDTH, 4, number of flip-flop channels (1..8)
SYNC_STAGES, 2, synchroniser flops on a/b (0 = no synchroniser, inputs used directly)
CNT_W, 8, width of the change-event counter

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  synchronous, active-low reset
en  input  1  1 = channels update per mode; 0 = hold q (load still works)
mode  input  2  00 T, 01 D, 10 JK, 11 SR
edge_mode  input  1  1 = T/J/K/S/R act only on rising edge of the synchronised input; 0 = level
a  input  WIDTH  per channel: T / D / J / S
b  input  WIDTH  per channel: K / R; ignored in T and D modes
load  input  1  synchronous parallel load
load_val  input  WIDTH  value loaded into q
cnt_clr  input  1  synchronous clear of change counter
q  output  WIDTH  flip-flop state
qbar  output  WIDTH  bitwise ~q (combinational from q)
chg  output  1  registered; 1 in the cycle q shows a new value differing from the previous q
sr_err  output  1  registered; 1 when any channel saw S=R=1 (effective) in SR mode with en=1, load=0
change_cnt  output  CNT_W  number of cycles with chg=1, saturating

Behaviour:
- All registers update only on posedge clk. Nothing is asynchronous.
- Reset (rst_n=0 at a clock edge) clears sync chains, edge-history regs, q, chg, sr_err and change_cnt to 0. qbar therefore reads all ones. Reset overrides every other input.
- Reset mid-operation discards in-flight synchroniser contents. The first post-reset edge detect compares against 0, so an input already high produces a rising edge once it emerges from the chain.
- Synchroniser: a_s/b_s = a/b delayed SYNC_STAGES cycles.
- Edge history: a_p/b_p are registered copies of a_s/b_s, updated every non-reset cycle regardless of en, load or mode. Edges occurring while en=0 are lost.
- Effective command per channel:
  - edge_mode=1 and mode≠D: x_e = x_s & ~x_p.
  - Otherwise: x_e = x_s.
  - D mode always uses the level value a_s.
- Next-state priority: load > en > hold.
  - load=1: q ← load_val.
  - load=0, en=0: q holds.
  - load=0, en=1:
    - T: q ← q ^ a_e.
    - D: q ← a_s.
    - JK: 00 hold, 01 (J=0,K=1) reset, 10 set, 11 toggle.
    - SR: 00 hold, 01 (S=0,R=1) clear, 10 set, 11 hold and flag sr_err.
- mode and edge_mode changes take effect at the next edge; no pipeline flush.
- Latency:
  - Pin-to-q is SYNC_STAGES+1 cycles in level or edge mode.
  - load and en act in 1 cycle.
  - chg and sr_err are valid in the same cycle as the resulting q.
- chg = (q_next ≠ q), registered. A load of the current value gives chg=0.
- sr_err is a one-cycle pulse per offending cycle. It is 0 in all other modes.
- change_cnt:
  - Increments by 1 on each cycle where the registered chg becomes 1.
  - Saturates at 2^CNT_W−1.
  - cnt_clr=1 forces 0 and wins over a simultaneous increment.

Test Plan:
1. Reset/T-level: rst_n=0 for 2 clks, then rst_n=1, mode=00, edge_mode=0, en=1, a=4'b0001 held. Expect q=0000, qbar=1111 during reset. q[0] first goes 1 at clock 3 after a is applied (SYNC_STAGES=2), then toggles every clock; chg=1 every cycle; change_cnt counts 1,2,3…
2. T-edge: edge_mode=1, pulse a[1] high for 5 cycles. Expect q[1] toggles exactly once, 3 clocks after the rise; a second rise after a low cycle toggles it back to 0.
3. JK/SR truth tables: sweep a/b over 00/01/10/11 on all 4 channels from q=0101 in JK, then SR. Expect JK 11 → q=1010. SR 11 → q holds 0101 and sr_err=1 for exactly one cycle; JK 11 gives sr_err=0.
4. Priority: en=0, load=1, load_val=1100, T mode with a=1111. Expect q=1100 next clock and chg=1. Then load=0, en=0: q holds 1100, chg=0. A repeat load of 1100 gives chg=0.
5. Counter saturation/clear: CNT_W=3, continuous T toggling. Expect change_cnt reaches 7 and stays. cnt_clr=1 on a toggling cycle gives 0 next clock; cnt_clr=0 resumes from 1.
6. Reset mid-operation: with a=1111 in flight in the sync chain (D mode), assert rst_n=0 for 1 clk. Expect q=0000 and chg=0 on that clock. After release, q=1111 appears only after SYNC_STAGES+1 clocks.

Source files
------------

// File: rtl/tff_bank_multimode.sv
// tff_bank_multimode
// ------------------
// A bank of WIDTH flip-flop channels. One shared 2-bit mode selects T, D, JK
// or SR behaviour for every channel. The a/b pins pass through an optional
// synchroniser chain first. In T, JK and SR modes the commands can be used
// as levels or as rising edges.
// The bank also provides a parallel load, a registered change strobe, a
// registered SR-conflict pulse and a saturating change-event counter.
//
// Ports:
//   clk        : clock; all state updates on its rising edge
//   rst_n      : synchronous, active-low reset
//   en         : 1 = channels follow the mode; 0 = hold q (load still works)
//   mode       : 00 T, 01 D, 10 JK, 11 SR
//   edge_mode  : 1 = T/J/K/S/R act only on a rising edge of the synced input
//   a          : per channel T / D / J / S
//   b          : per channel K / R (ignored in T and D modes)
//   load       : synchronous parallel load of load_val into q
//   load_val   : value loaded into q
//   cnt_clr    : synchronous clear of the change counter
//   q, qbar    : flip-flop state and its complement
//   chg        : 1 in the cycle q shows a value different from the previous q
//   sr_err     : 1 in the cycle following an SR-mode S=R=1 command
//   change_cnt : saturating count of cycles with chg=1

module tff_bank_multimode #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             edge_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             chg,
    output logic             sr_err,
    output logic [CNT_W-1:0] change_cnt
);

    typedef enum logic [1:0] {
        MODE_T  = 2'b00,
        MODE_D  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mode_e            mode_sel;
    logic [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0] a_p_q, a_p_d, b_p_q, b_p_d;
    logic [WIDTH-1:0] a_e, b_e;
    logic [WIDTH-1:0] q_q, q_d;
    logic             chg_q, chg_d;
    logic             sr_err_q, sr_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             use_edge;

    assign mode_sel = mode_e'(mode);

    // Synchroniser chain. Stage 0 captures the pin, and the last stage feeds
    // the rest of the logic. Reset empties the chain, so any data still in
    // flight is discarded.
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [WIDTH-1:0] a_chain_q [SYNC_STAGES];
            logic [WIDTH-1:0] a_chain_d [SYNC_STAGES];
            logic [WIDTH-1:0] b_chain_q [SYNC_STAGES];
            logic [WIDTH-1:0] b_chain_d [SYNC_STAGES];

            always_comb begin
                a_chain_d[0] = a;
                b_chain_d[0] = b;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    a_chain_d[i] = a_chain_q[i-1];
                    b_chain_d[i] = b_chain_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    if (!rst_n) begin
                        a_chain_q[i] <= '0;
                        b_chain_q[i] <= '0;
                    end else begin
                        a_chain_q[i] <= a_chain_d[i];
                        b_chain_q[i] <= b_chain_d[i];
                    end
                end
            end

            assign a_s = a_chain_q[SYNC_STAGES-1];
            assign b_s = b_chain_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign a_s = a;
            assign b_s = b;
        end
    endgenerate

    // The edge history tracks the synced inputs on every cycle, whatever the
    // values of en, load and mode. As a result, an edge that arrives while
    // the bank is disabled is consumed and lost.
    // D mode always samples the level, even when edge_mode is set.
    always_comb begin
        a_p_d    = a_s;
        b_p_d    = b_s;
        use_edge = edge_mode && (mode_sel != MODE_D);
        a_e      = use_edge ? (a_s & ~a_p_q) : a_s;
        b_e      = use_edge ? (b_s & ~b_p_q) : b_s;
    end

    // Next-state logic. Priority is load, then en, then hold. The JK and SR
    // cases are written as bitwise equations so that all channels are
    // computed in parallel.
    always_comb begin
        q_d      = q_q;
        sr_err_d = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            case (mode_sel)
                MODE_T:  q_d = q_q ^ a_e;
                MODE_D:  q_d = a_s;
                MODE_JK: q_d = (a_e & ~q_q) | (~b_e & q_q);
                MODE_SR: begin
                    // S=R=1 holds the channel and raises the error flag
                    q_d      = (a_e & ~b_e) | (q_q & ~(a_e ^ b_e));
                    sr_err_d = |(a_e & b_e);
                end
                default: q_d = q_q;
            endcase
        end

        chg_d = (q_d != q_q);

        // The counter steps on the same edge that registers chg=1, so it
        // always equals the number of chg=1 cycles seen so far. A clear
        // takes priority over an increment in the same cycle.
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (chg_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_p_q    <= '0;
            b_p_q    <= '0;
            q_q      <= '0;
            chg_q    <= 1'b0;
            sr_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_p_q    <= a_p_d;
            b_p_q    <= b_p_d;
            q_q      <= q_d;
            chg_q    <= chg_d;
            sr_err_q <= sr_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign q          = q_q;
    assign qbar       = ~q_q;
    assign chg        = chg_q;
    assign sr_err     = sr_err_q;
    assign change_cnt = cnt_q;

endmodule

// File: tb/tb_tff_bank_multimode.sv
// Testbench for tff_bank_multimode (WIDTH=4, SYNC_STAGES=2, CNT_W=3).
// A behavioural model predicts each cycle's outputs at the time the stimulus
// is driven. The prediction is pushed onto a scoreboard queue, then popped
// and compared once the DUT has clocked. Directed checks pin down the
// behaviours that matter most.

module tb_tff_bank_multimode;

    localparam int SYNC = 2;
    localparam logic [1:0] M_T  = 2'b00;
    localparam logic [1:0] M_D  = 2'b01;
    localparam logic [1:0] M_JK = 2'b10;
    localparam logic [1:0] M_SR = 2'b11;

    localparam logic [3:0] PAT_A  [5] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hC};
    localparam logic [3:0] PAT_B  [5] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hA};
    localparam logic [3:0] EXP_JK [5] = '{4'h5, 4'hF, 4'h0, 4'hA, 4'hD};
    localparam logic [3:0] EXP_SR [5] = '{4'h5, 4'hF, 4'h0, 4'h5, 4'h5};

    typedef struct packed {
        logic [3:0] q;
        logic       chg;
        logic       err;
        logic [2:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       edge_mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       load;
    logic [3:0] load_val;
    logic       cnt_clr;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       chg;
    logic       sr_err;
    logic [2:0] change_cnt;

    int check_count = 0;
    int pass_count  = 0;
    int step_num    = 0;

    exp_t       sb[$];
    logic [3:0] a_hist[$];
    logic [3:0] b_hist[$];
    logic [3:0] m_q, m_ap, m_bp;
    logic       m_chg, m_err;
    logic [2:0] m_cnt;

    tff_bank_multimode #(
        .WIDTH      (4),
        .SYNC_STAGES(SYNC),
        .CNT_W      (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .edge_mode (edge_mode),
        .a         (a),
        .b         (b),
        .load      (load),
        .load_val  (load_val),
        .cnt_clr   (cnt_clr),
        .q         (q),
        .qbar      (qbar),
        .chg       (chg),
        .sr_err    (sr_err),
        .change_cnt(change_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        else
            pass_count++;
    endtask

    // Reference model: advance one clock using the inputs currently driven.
    task automatic modelStep();
        logic [3:0] as_v, bs_v, ae, be, nq;
        exp_t e;
        if (!rst_n) begin
            m_q = '0; m_chg = 1'b0; m_err = 1'b0; m_cnt = '0;
            m_ap = '0; m_bp = '0;
            a_hist.delete(); b_hist.delete();
            repeat (SYNC) begin
                a_hist.push_back(4'h0);
                b_hist.push_back(4'h0);
            end
        end else begin
            as_v = a_hist.pop_front(); a_hist.push_back(a);
            bs_v = b_hist.pop_front(); b_hist.push_back(b);
            if (edge_mode && mode != M_D) begin
                ae = as_v & ~m_ap;
                be = bs_v & ~m_bp;
            end else begin
                ae = as_v;
                be = bs_v;
            end
            m_ap = as_v;
            m_bp = bs_v;
            nq = m_q;
            m_err = 1'b0;
            if (load) begin
                nq = load_val;
            end else if (en) begin
                for (int i = 0; i < 4; i++) begin
                    case (mode)
                        M_T: nq[i] = ae[i] ? ~m_q[i] : m_q[i];
                        M_D: nq[i] = as_v[i];
                        M_JK: case ({ae[i], be[i]})
                            2'b01:   nq[i] = 1'b0;
                            2'b10:   nq[i] = 1'b1;
                            2'b11:   nq[i] = ~m_q[i];
                            default: nq[i] = m_q[i];
                        endcase
                        default: case ({ae[i], be[i]})
                            2'b01:   nq[i] = 1'b0;
                            2'b10:   nq[i] = 1'b1;
                            2'b11:   begin nq[i] = m_q[i]; m_err = 1'b1; end
                            default: nq[i] = m_q[i];
                        endcase
                    endcase
                end
            end
            m_chg = (nq != m_q);
            if (cnt_clr) m_cnt = 3'd0;
            else if (m_chg && m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
            m_q = nq;
        end
        e.q = m_q; e.chg = m_chg; e.err = m_err; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic rn, input logic e, input logic [1:0] m,
                                 input logic em, input logic [3:0] av, input logic [3:0] bv,
                                 input logic ld, input logic [3:0] lv, input logic clr);
        exp_t x;
        rst_n = rn; en = e; mode = m; edge_mode = em;
        a = av; b = bv; load = ld; load_val = lv; cnt_clr = clr;
        modelStep();
        @(posedge clk);
        #1;
        step_num++;
        x = sb.pop_front();
        checkOutput($sformatf("q@%0d", step_num), {4'b0, q}, {4'b0, x.q});
        checkOutput($sformatf("qbar@%0d", step_num), {4'b0, qbar}, {4'b0, ~x.q});
        checkOutput($sformatf("chg@%0d", step_num), {7'b0, chg}, {7'b0, x.chg});
        checkOutput($sformatf("sr_err@%0d", step_num), {7'b0, sr_err}, {7'b0, x.err});
        checkOutput($sformatf("cnt@%0d", step_num), {5'b0, change_cnt}, {5'b0, x.cnt});
    endtask

    initial begin
        logic [1:0] md;
        rst_n = 1'b0; en = 1'b0; mode = M_T; edge_mode = 1'b0;
        a = '0; b = '0; load = 1'b0; load_val = '0; cnt_clr = 1'b0;

        // Reset, then T level toggling with counter saturation and clear
        repeat (2) begin
            applyStimulus(1'b0, 1'b1, M_T, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
            checkOutput("rst_q", {4'b0, q}, 8'h00);
            checkOutput("rst_qbar", {4'b0, qbar}, 8'h0F);
        end
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b1, M_T, 1'b0, 4'h1, 4'h0, 1'b0, 4'h0, (i == 11));
            if (i == 2)  checkOutput("t1_not_yet", {4'b0, q}, 8'h00);
            if (i == 3)  checkOutput("t1_first_toggle", {4'b0, q}, 8'h01);
            if (i == 4)  checkOutput("t1_second_toggle", {4'b0, q}, 8'h00);
            if (i == 10) checkOutput("t1_cnt_sat", {5'b0, change_cnt}, 8'd7);
            if (i == 11) checkOutput("t1_cnt_clr", {5'b0, change_cnt}, 8'd0);
            if (i == 12) checkOutput("t1_cnt_resume", {5'b0, change_cnt}, 8'd1);
        end

        // T edge mode: one toggle per rising edge
        repeat (3) applyStimulus(1'b1, 1'b1, M_T, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, M_T, 1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, M_T, 1'b1, 4'h2, 4'h0, 1'b0, 4'h0, 1'b0);
            if (i == 2) checkOutput("t2_pre_edge", {4'b0, q}, 8'h00);
            if (i == 3) checkOutput("t2_edge_toggle", {4'b0, q}, 8'h02);
            if (i == 5) checkOutput("t2_held_high", {4'b0, q}, 8'h02);
        end
        applyStimulus(1'b1, 1'b1, M_T, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, M_T, 1'b1, 4'h2, 4'h0, 1'b0, 4'h0, 1'b0);
            if (i == 3) checkOutput("t2_second_edge", {4'b0, q}, 8'h00);
            if (i == 5) checkOutput("t2_second_held", {4'b0, q}, 8'h00);
        end
        repeat (3) applyStimulus(1'b1, 1'b1, M_T, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);

        // JK then SR truth tables, each pattern starting from q=0101
        for (int mi = 0; mi < 2; mi++) begin
            md = (mi == 0) ? M_JK : M_SR;
            for (int p = 0; p < 5; p++) begin
                applyStimulus(1'b1, 1'b1, md, 1'b0, PAT_A[p], PAT_B[p], 1'b1, 4'h5, 1'b0);
                if (mi == 1 && p == 4)
                    checkOutput("t3_sr_err_one_cycle", {7'b0, sr_err}, 8'h00);
                repeat (2) applyStimulus(1'b1, 1'b1, md, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
                checkOutput($sformatf("t3_q_m%0d_p%0d", mi, p), {4'b0, q},
                            {4'b0, (mi == 0) ? EXP_JK[p] : EXP_SR[p]});
                checkOutput($sformatf("t3_err_m%0d_p%0d", mi, p), {7'b0, sr_err},
                            {7'b0, (mi == 1 && p >= 3)});
            end
        end

        // Priority: load beats en=0, hold while disabled, reload of same value
        applyStimulus(1'b1, 1'b0, M_T, 1'b0, 4'hF, 4'h0, 1'b1, 4'hC, 1'b0);
        checkOutput("t4_load_q", {4'b0, q}, 8'h0C);
        checkOutput("t4_load_chg", {7'b0, chg}, 8'h01);
        repeat (3) begin
            applyStimulus(1'b1, 1'b0, M_T, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0);
            checkOutput("t4_hold_q", {4'b0, q}, 8'h0C);
            checkOutput("t4_hold_chg", {7'b0, chg}, 8'h00);
        end
        applyStimulus(1'b1, 1'b0, M_T, 1'b0, 4'hF, 4'h0, 1'b1, 4'hC, 1'b0);
        checkOutput("t4_reload_chg", {7'b0, chg}, 8'h00);
        repeat (2) applyStimulus(1'b1, 1'b0, M_T, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);

        // Reset mid-operation with D-mode data in the chain
        applyStimulus(1'b1, 1'b1, M_D, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, M_D, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0);
        checkOutput("t6_rst_q", {4'b0, q}, 8'h00);
        checkOutput("t6_rst_chg", {7'b0, chg}, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, M_D, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0);
            if (i == 2) checkOutput("t6_still_zero", {4'b0, q}, 8'h00);
            if (i == 3) checkOutput("t6_arrived", {4'b0, q}, 8'h0F);
        end

        // Random mix of every input, scored against the model
        for (int i = 0; i < 80; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0),
                          4'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
